raizing_gp9001_bus: RTL and testbench

CPU-side bus adapter that sits directly upstream of `raizing_video`'s GP9001 port. It decodes 68000 accesses to the GP9001 window into single-cycle operation strobes (`GP9001_OP_*`) plus a held `GP9001CS`. It then waits for `GP9001ACK`, latches read data and returns `CPU_DTACK_N` to the CPU. It is instantiated once per game top, between the 68000 address decoder and the video block.

---
 rtl/raizing_gp9001_pkg.sv | 35 +++
 rtl/raizing_gp9001_opdec.sv | 23 ++
 rtl/raizing_gp9001_bus.sv | 158 +++++++++++++++
 tb/tb_raizing_gp9001_bus.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/raizing_gp9001_pkg.sv
// Shared types and constants for the GP9001 CPU bus adapter and its op decoder.
package raizing_gp9001_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE,
    ST_RELEASE
  } gp_state_e;

  localparam logic [1:0] GP_OFS_PTR  = 2'd0;
  localparam logic [1:0] GP_OFS_DATA = 2'd1;
  localparam logic [1:0] GP_OFS_SEL  = 2'd2;
  localparam logic [1:0] GP_OFS_REG  = 2'd3;

  localparam int GP_STATUS_VBL_BIT = 15;

  // Bit positions inside the one-hot operation vector.
  localparam int GP_OP_W           = 6;
  localparam int GP_OP_SELECT_REG  = 0;
  localparam int GP_OP_WRITE_REG   = 1;
  localparam int GP_OP_WRITE_RAM   = 2;
  localparam int GP_OP_READ_RAM_H  = 3;
  localparam int GP_OP_READ_RAM_L  = 4;
  localparam int GP_OP_SET_RAM_PTR = 5;

  function automatic logic [15:0] gp_status_word(input logic vbl);
    logic [15:0] w;
    w = '0;
    w[GP_STATUS_VBL_BIT] = vbl;
    return w;
  endfunction

endpackage

// File: rtl/raizing_gp9001_opdec.sv
// Combinational decode of window offset and direction into a one-hot GP9001 operation.
module raizing_gp9001_opdec
  import raizing_gp9001_pkg::*;
(
  input  logic [1:0]         ofs_i,
  input  logic               rnw_i,
  output logic [GP_OP_W-1:0] op_o,
  output logic               local_o
);

  always_comb begin
    op_o    = '0;
    local_o = 1'b0;
    case (ofs_i)
      GP_OFS_PTR:  if (rnw_i) local_o = 1'b1; else op_o[GP_OP_SET_RAM_PTR] = 1'b1;
      GP_OFS_DATA: if (rnw_i) op_o[GP_OP_READ_RAM_H] = 1'b1; else op_o[GP_OP_WRITE_RAM] = 1'b1;
      GP_OFS_SEL:  if (rnw_i) op_o[GP_OP_READ_RAM_L] = 1'b1; else op_o[GP_OP_SELECT_REG] = 1'b1;
      GP_OFS_REG:  if (rnw_i) local_o = 1'b1; else op_o[GP_OP_WRITE_REG] = 1'b1;
      default:     local_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/raizing_gp9001_bus.sv
// 68000-to-GP9001 bus adapter: op strobes, ACK wait, read latch and DTACK handshake.
// Optional ACK timeout enabled by defining RAIZING_GP9001_TIMEOUT_EN.
module raizing_gp9001_bus
  import raizing_gp9001_pkg::*;
#(
  parameter int TIMEOUT_W = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        CPU_CS,
  input  logic [1:0]  CPU_ADDR,
  input  logic        CPU_RNW,
  input  logic        CPU_UDS_N,
  input  logic        CPU_LDS_N,
  input  logic [15:0] CPU_DIN,
  output logic [15:0] CPU_DOUT,
  output logic        CPU_DTACK_N,
  input  logic        VBLANK,
  output logic        GP9001CS,
  output logic [15:0] GP9001DIN,
  input  logic [15:0] GP9001DOUT,
  input  logic        GP9001ACK,
  output logic        GP9001_OP_SELECT_REG,
  output logic        GP9001_OP_WRITE_REG,
  output logic        GP9001_OP_WRITE_RAM,
  output logic        GP9001_OP_READ_RAM_H,
  output logic        GP9001_OP_READ_RAM_L,
  output logic        GP9001_OP_SET_RAM_PTR,
  output logic        BUS_ERR
);

  gp_state_e          state_q, state_d;
  logic [GP_OP_W-1:0] op_q, op_d, dec_op;
  logic               dec_local;
  logic [15:0]        dout_q, dout_d, din_q, din_d;
  logic               dtack_n_q, dtack_n_d, cs_q, cs_d;
  logic               rnw_q, rnw_d, abort_q, abort_d, err_q, err_d;
  logic               start, released, abort_now, tmo_hit;

  assign start     = CPU_CS && !(CPU_UDS_N && CPU_LDS_N);
  assign released  = !CPU_CS || (CPU_UDS_N && CPU_LDS_N);
  assign abort_now = abort_q || !CPU_CS;

  raizing_gp9001_opdec u_opdec (
    .ofs_i   (CPU_ADDR),
    .rnw_i   (CPU_RNW),
    .op_o    (dec_op),
    .local_o (dec_local)
  );

`ifdef RAIZING_GP9001_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'((2 ** TIMEOUT_W) - 2);
  logic [TIMEOUT_W-1:0] tmo_q;

  // Counter value equals completed WAIT cycles, so the hit lands on WAIT cycle 2^W-1.
  assign tmo_hit = (state_q == ST_WAIT) && (tmo_q == TMO_LAST);

  always_ff @(posedge CLK) begin
    if (RESET || state_q != ST_WAIT) tmo_q <= '0;
    else                             tmo_q <= tmo_q + 1'b1;
  end
`else
  localparam logic [TIMEOUT_W-1:0] TMO_NONE = '0;
  assign tmo_hit = (TMO_NONE != '0);
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      dout_q    <= '0;
      din_q     <= '0;
      dtack_n_q <= 1'b1;
      cs_q      <= 1'b0;
      rnw_q     <= 1'b0;
      abort_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      dout_q    <= dout_d;
      din_q     <= din_d;
      dtack_n_q <= dtack_n_d;
      cs_q      <= cs_d;
      rnw_q     <= rnw_d;
      abort_q   <= abort_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start) state_d = dec_local ? ST_DONE : ST_ISSUE;
      ST_ISSUE:   state_d = GP9001ACK ? (abort_now ? ST_IDLE : ST_DONE) : ST_WAIT;
      ST_WAIT:    if (GP9001ACK || tmo_hit) state_d = abort_now ? ST_IDLE : ST_DONE;
      ST_DONE:    state_d = ST_RELEASE;
      ST_RELEASE: if (released) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    op_d      = '0;
    dout_d    = dout_q;
    din_d     = din_q;
    dtack_n_d = dtack_n_q;
    cs_d      = cs_q;
    rnw_d     = rnw_q;
    abort_d   = abort_q;
    err_d     = err_q;
    case (state_q)
      ST_IDLE: begin
        dtack_n_d = 1'b1;
        cs_d      = 1'b0;
        abort_d   = 1'b0;
        if (start) begin
          rnw_d = CPU_RNW;
          if (!CPU_RNW) din_d = CPU_DIN;
          if (dec_local) begin
            dout_d = gp_status_word(VBLANK);
          end else begin
            cs_d = 1'b1;
            op_d = dec_op;
          end
        end
      end
      ST_ISSUE, ST_WAIT: begin
        // The strobe is already out, so a CPU abort only suppresses DTACK.
        if (!CPU_CS) abort_d = 1'b1;
        if (GP9001ACK) begin
          cs_d = 1'b0;
          if (rnw_q) dout_d = GP9001DOUT;
        end else if (tmo_hit) begin
          cs_d  = 1'b0;
          err_d = 1'b1;
          if (rnw_q) dout_d = 16'hFFFF;
        end
      end
      ST_DONE:    dtack_n_d = 1'b0;
      ST_RELEASE: if (released) dtack_n_d = 1'b1;
      default:    dtack_n_d = 1'b1;
    endcase
  end

  assign CPU_DOUT              = dout_q;
  assign CPU_DTACK_N           = dtack_n_q;
  assign GP9001CS              = cs_q;
  assign GP9001DIN             = din_q;
  assign GP9001_OP_SELECT_REG  = op_q[GP_OP_SELECT_REG];
  assign GP9001_OP_WRITE_REG   = op_q[GP_OP_WRITE_REG];
  assign GP9001_OP_WRITE_RAM   = op_q[GP_OP_WRITE_RAM];
  assign GP9001_OP_READ_RAM_H  = op_q[GP_OP_READ_RAM_H];
  assign GP9001_OP_READ_RAM_L  = op_q[GP_OP_READ_RAM_L];
  assign GP9001_OP_SET_RAM_PTR = op_q[GP_OP_SET_RAM_PTR];
  assign BUS_ERR               = err_q;

endmodule

// File: tb/tb_raizing_gp9001_bus.sv
// Directed plus randomized bench for raizing_gp9001_bus against a transaction-level model.
module tb_raizing_gp9001_bus;

  localparam int TW = 4;

  logic        CLK = 1'b0;
  logic        RESET, CPU_CS, CPU_RNW, CPU_UDS_N, CPU_LDS_N, VBLANK, GP9001ACK;
  logic [1:0]  CPU_ADDR;
  logic [15:0] CPU_DIN, GP9001DOUT;
  logic [15:0] CPU_DOUT, GP9001DIN;
  logic        CPU_DTACK_N, GP9001CS, BUS_ERR;
  logic        op_sel, op_wreg, op_wram, op_rh, op_rl, op_ptr;
  logic [5:0]  ops;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_dout = '0;
  logic [15:0] exp_din  = '0;
  logic        exp_err  = 1'b0;

  assign ops = {op_ptr, op_rl, op_rh, op_wram, op_wreg, op_sel};

  raizing_gp9001_bus #(.TIMEOUT_W(TW)) dut (
    .CLK                   (CLK),
    .RESET                 (RESET),
    .CPU_CS                (CPU_CS),
    .CPU_ADDR              (CPU_ADDR),
    .CPU_RNW               (CPU_RNW),
    .CPU_UDS_N             (CPU_UDS_N),
    .CPU_LDS_N             (CPU_LDS_N),
    .CPU_DIN               (CPU_DIN),
    .CPU_DOUT              (CPU_DOUT),
    .CPU_DTACK_N           (CPU_DTACK_N),
    .VBLANK                (VBLANK),
    .GP9001CS              (GP9001CS),
    .GP9001DIN             (GP9001DIN),
    .GP9001DOUT            (GP9001DOUT),
    .GP9001ACK             (GP9001ACK),
    .GP9001_OP_SELECT_REG  (op_sel),
    .GP9001_OP_WRITE_REG   (op_wreg),
    .GP9001_OP_WRITE_RAM   (op_wram),
    .GP9001_OP_READ_RAM_H  (op_rh),
    .GP9001_OP_READ_RAM_L  (op_rl),
    .GP9001_OP_SET_RAM_PTR (op_ptr),
    .BUS_ERR               (BUS_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected op bit for an access: -1 for local status reads.
  function automatic int exp_op(input logic [1:0] ofs, input logic rnw);
    case ({rnw, ofs})
      3'b000:  return 5;
      3'b001:  return 2;
      3'b010:  return 0;
      3'b011:  return 1;
      3'b101:  return 3;
      3'b110:  return 4;
      default: return -1;
    endcase
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One complete CPU access; ack_d = ACK delay after ISSUE, -1 = never ACK.
  task automatic run_access(input logic [1:0] ofs, input logic rnw, input logic [15:0] wdata,
                            input int ack_d, input logic [15:0] rdata, input logic vbl);
    int   eidx, exp_dt, issue_c, dt_c, pulses, cs_cnt, hit_idx, hold, smode;
    bit   is_local;
    logic dt_dropped;
    eidx     = exp_op(ofs, rnw);
    is_local = (eidx < 0);
    exp_dt   = is_local ? 1 : (ack_d < 0 ? (1 << TW) + 1 : ack_d + 2);
    CPU_ADDR = ofs; CPU_RNW = rnw; CPU_DIN = wdata; VBLANK = vbl; GP9001DOUT = rdata;
    smode = rnw ? 0 : int'($urandom_range(0, 2));
    CPU_UDS_N = (smode == 2);
    CPU_LDS_N = (smode == 1);
    CPU_CS = 1'b1;
    issue_c = -1; dt_c = -1; pulses = 0; cs_cnt = 0; hit_idx = -1;
    for (int c = 0; c < 60 && dt_c < 0; c++) begin
      tick();
      GP9001ACK = 1'b0;
      for (int k = 0; k < 6; k++)
        if (ops[k]) begin
          pulses++;
          hit_idx = k;
          if (issue_c < 0) issue_c = c;
        end
      if (GP9001CS) cs_cnt++;
      if (!CPU_DTACK_N) dt_c = c;
      if (ack_d >= 0 && issue_c >= 0 && c - issue_c == ack_d) GP9001ACK = 1'b1;
    end
    if (rnw) exp_dout = is_local ? {vbl, 15'h0000} : (ack_d < 0 ? 16'hFFFF : rdata);
    else     exp_din  = wdata;
    if (ack_d < 0 && !is_local) exp_err = 1'b1;
    chk("dtack_latency", dt_c, exp_dt);
    chk("cpu_dout", CPU_DOUT, exp_dout);
    chk("gp_din", GP9001DIN, exp_din);
    chk("bus_err", BUS_ERR, exp_err);
    chk("cs_cycles", cs_cnt, is_local ? 0 : exp_dt - 1);
    if (!is_local) begin
      chk("issue_cycle", issue_c, 0);
      chk("op_select", hit_idx, eidx);
    end
    hold = $urandom_range(0, 2);
    dt_dropped = 1'b0;
    for (int h = 0; h < hold; h++) begin
      tick();
      if (CPU_DTACK_N !== 1'b0) dt_dropped = 1'b1;
      pulses += $countones(ops);
    end
    chk("dtack_hold", dt_dropped, 1'b0);
    chk("op_pulses", pulses, is_local ? 0 : 1);
    if ($urandom_range(0, 1) == 0) CPU_CS = 1'b0;
    else begin CPU_UDS_N = 1'b1; CPU_LDS_N = 1'b1; end
    tick();
    chk("dtack_release", CPU_DTACK_N, 1'b1);
    CPU_CS = 1'b0; CPU_UDS_N = 1'b1; CPU_LDS_N = 1'b1;
    tick();
    chk("idle_quiet", {GP9001CS, CPU_DTACK_N, ops}, {1'b0, 1'b1, 6'b0});
  endtask

  initial begin
    logic dt_seen;
    RESET = 1'b1; CPU_CS = 1'b0; CPU_RNW = 1'b1; CPU_UDS_N = 1'b1; CPU_LDS_N = 1'b1;
    VBLANK = 1'b0; GP9001ACK = 1'b0; CPU_ADDR = '0; CPU_DIN = '0; GP9001DOUT = '0;
    repeat (3) tick();
    RESET = 1'b0;
    chk("rst_dout", CPU_DOUT, 16'h0000);
    chk("rst_dtack", CPU_DTACK_N, 1'b1);
    chk("rst_cs", GP9001CS, 1'b0);
    chk("rst_din", GP9001DIN, 16'h0000);
    chk("rst_ops", ops, 6'b0);
    chk("rst_err", BUS_ERR, 1'b0);
    tick();

    run_access(2'd1, 1'b0, 16'h1234, 2, 16'h0000, 1'b0);
    run_access(2'd1, 1'b1, 16'h0000, 0, 16'hBEEF, 1'b0);
    run_access(2'd3, 1'b1, 16'h0000, 0, 16'h1111, 1'b1);
    run_access(2'd0, 1'b1, 16'h0000, 0, 16'h2222, 1'b0);
    run_access(2'd2, 1'b1, 16'h0000, 1, 16'hA5C3, 1'b0);

    for (int i = 0; i < 24; i++)
      run_access(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 16'($urandom),
                 int'($urandom_range(0, 4)), 16'($urandom), 1'($urandom_range(0, 1)));

    // CPU abort during WAIT: operation completes, no DTACK.
    CPU_ADDR = 2'd0; CPU_RNW = 1'b0; CPU_DIN = 16'h5A5A;
    CPU_UDS_N = 1'b0; CPU_LDS_N = 1'b0; CPU_CS = 1'b1;
    tick();
    chk("abort_issue_op", ops, 6'b100000);
    tick();
    chk("abort_wait_cs", GP9001CS, 1'b1);
    CPU_CS = 1'b0; CPU_UDS_N = 1'b1; CPU_LDS_N = 1'b1;
    tick();
    GP9001ACK = 1'b1;
    tick();
    GP9001ACK = 1'b0;
    chk("abort_cs_drop", GP9001CS, 1'b0);
    dt_seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (CPU_DTACK_N !== 1'b1) dt_seen = 1'b1;
      tick();
    end
    chk("abort_no_dtack", dt_seen, 1'b0);
    exp_din = 16'h5A5A;
    chk("abort_din", GP9001DIN, exp_din);
    run_access(2'd2, 1'b0, 16'h0C0D, 1, 16'h0000, 1'b0);

`ifdef RAIZING_GP9001_TIMEOUT_EN
    run_access(2'd1, 1'b1, 16'h0000, -1, 16'h1357, 1'b0);
    run_access(2'd3, 1'b0, 16'h7777, 1, 16'h0000, 1'b0);
    chk("err_sticky", BUS_ERR, 1'b1);
`endif

    // RESET while waiting for ACK.
    CPU_ADDR = 2'd1; CPU_RNW = 1'b1; CPU_UDS_N = 1'b0; CPU_LDS_N = 1'b0; CPU_CS = 1'b1;
    tick();
    tick();
    chk("pre_reset_cs", GP9001CS, 1'b1);
    RESET = 1'b1; CPU_CS = 1'b0; CPU_UDS_N = 1'b1; CPU_LDS_N = 1'b1;
    tick();
    RESET = 1'b0;
    exp_dout = '0; exp_din = '0; exp_err = 1'b0;
    chk("midrst_cs", GP9001CS, 1'b0);
    chk("midrst_dtack", CPU_DTACK_N, 1'b1);
    chk("midrst_dout_err", {CPU_DOUT, BUS_ERR}, {exp_dout, exp_err});
    tick();
    run_access(2'd3, 1'b0, 16'hCAFE, 1, 16'h0000, 1'b0);
    run_access(2'd2, 1'b1, 16'h0000, 3, 16'h4321, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
